stack_painter: RTL
==================

# stack_painter

Pixel-side consumer of the stack description (pos_x, pos_y, height, colors) that the stack logic publishes. Snapshots the description once per frame during vertical blanking and tracks block rows line by line. For every active pixel it produces an 8-bit RGB value plus an ownership flag for the VGA compositor, with a fixed 2-tick pipeline latency.

## Interface
- BLOCK_W, 150: block width in pixels
- BLOCK_H, 20: block height in pixels
- V_LATCH, 480: vcount on which the snapshot is taken, first blanking line
- PAL1, 8'hE0: RGB for colour code 01
- PAL2, 8'h1C: RGB for colour code 10
- PAL3, 8'hFC: RGB for colour code 11
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate enable; hcount, vcount and video_on are valid when it is high
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- video_on  in  1  active-video qualifier
- pos_x  in  10  left edge of the stack
- pos_y  in  10  top row of block 0, the bottom block
- height  in  10  number of blocks
- colors  in  32  16×2-bit colour codes; block i uses colors[2i+1:2i]
- rgb  out  8  pixel colour {R[2:0],G[2:0],B[1:0]}
- stack_px  out  1  pixel belongs to a drawn block
- frame_ready  out  1  snapshot and row setup complete for the coming frame

## Operation
- Geometry:
  - Block i covers columns pos_x .. pos_x+BLOCK_W-1.
  - Block i covers rows pos_y-i*BLOCK_H .. pos_y-i*BLOCK_H+BLOCK_H-1.
  - Rows above 0 are clipped. Column compare uses 11-bit sums, so no wrap.
- Snapshot: on pix_en && hcount==0 && vcount==V_LATCH, register:
  - sx = pos_x
  - sy = pos_y
  - sc = colors
  - sh = min(height,16)
- Input changes at any other time do not affect the frame being drawn.
- Control FSM:
  - IDLE → LATCH on the snapshot event.
  - LATCH (1 clk): r = sy+BLOCK_H-1 (11 bit), q = 0, frame_ready = 0. Go to DIVIDE.
  - DIVIDE: each clk, if r ≥ BLOCK_H then r -= BLOCK_H and q += 1; else go to READY. Worst case 52 clk.
  - READY: frame_ready = 1. On the next snapshot event go to LATCH, which clears frame_ready.
- Row tracker, updated at each line start (pix_en && hcount==0):
  - vcount==0 (requires READY): idx = q, sub = r, valid = 1.
  - vcount in 1..479 with valid: if sub==0, then idx==0 clears valid; otherwise idx -= 1 and sub = BLOCK_H-1. If sub≠0, sub -= 1.
  - Line start at vcount==0 while not READY: valid = 0 for the whole frame.
  - row_hit = valid && idx < sh.
- Pixel pipeline, advances only on pix_en:
  - S1 registers: col_hit = (hcount ≥ sx) && (hcount < sx+BLOCK_W); code = sc[2·idx +: 2]; hit = row_hit && col_hit && video_on.
  - S2 registers outputs:
    - stack_px = hit && code≠00.
    - rgb = PALn for code n when stack_px, else 8'h00.
- Code 00 makes a block transparent: stack_px = 0.
- height = 0 draws nothing. height > 16 draws exactly 16 blocks.

## Timing
- Latency: the pixel sampled at pix_en tick t appears on rgb/stack_px after pix_en tick t+2. Outputs hold between ticks.
- Row tracker state for a line takes effect from that line's hcount==0 sample.
- Reset: synchronous. Next clk gives:
  - rgb = 0, stack_px = 0, frame_ready = 0
  - FSM = IDLE, valid = 0, sh = 0
  - pipeline registers cleared
- Reset mid-frame blanks the output until the next snapshot. Drawing resumes on the following frame.
- A snapshot event during DIVIDE restarts at LATCH. A new snapshot always wins.

## Test plan
- Reset, then a snapshot with pos_x=300, pos_y=360, height=1, colors=…_01:
  - line 360, hcount 300 → rgb=PAL1 and stack_px=1 two ticks later.
  - hcount 449 drawn, 450 not.
  - rows 359 and 380 dark, 379 drawn.
- height=3, colors[5:0]=11_10_01:
  - row 345 → PAL2
  - row 325 → PAL3
  - row 319 → 0
- pos_y=10, height=2:
  - q=1, r=9.
  - rows 0–9 show block 1, rows 10–29 show block 0, row 30 dark.
- height=20 with all codes 11 → rows pos_y-300 .. pos_y+19 drawn. Code 00 on block 2 → those 20 rows give stack_px=0.
- Change pos_x from 300 to 100 mid-frame at vcount=200 → rest of the frame still at 300. Next frame at 100. video_on low → rgb=0.
- Assert rst at vcount=370 → outputs 0 next clk, nothing drawn that frame. frame_ready rises ≤52 clk after the next snapshot.

Source files
------------

// File: rtl/stack_painter_if.sv
// Bundle between the VGA timing/stack logic and the stack painter.
// master: drives timing and stack description; slave: returns pixel data.
interface stack_painter_if;
    logic        pix_en;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        video_on;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [9:0]  height;
    logic [31:0] colors;
    logic [7:0]  rgb;
    logic        stack_px;
    logic        frame_ready;

    modport master (
        output pix_en, hcount, vcount, video_on,
        output pos_x, pos_y, height, colors,
        input  rgb, stack_px, frame_ready
    );

    modport slave (
        input  pix_en, hcount, vcount, video_on,
        input  pos_x, pos_y, height, colors,
        output rgb, stack_px, frame_ready
    );
endinterface

// File: rtl/stack_painter.sv
// Stack painter: snapshots the stack once per frame, tracks block rows
// per line and emits rgb/stack_px two pixel ticks after each sample.
// Ports: clk, rst (sync, active high), sp (slave side of stack_painter_if).
module stack_painter #(
    parameter int unsigned BLOCK_W = 150,
    parameter int unsigned BLOCK_H = 20,
    parameter int unsigned V_LATCH = 480,
    parameter logic [7:0]  PAL1    = 8'hE0,
    parameter logic [7:0]  PAL2    = 8'h1C,
    parameter logic [7:0]  PAL3    = 8'hFC
) (
    input  logic            clk,
    input  logic            rst,
    stack_painter_if.slave  sp
);

    localparam int SW = $clog2(BLOCK_H);
    localparam logic [10:0]   BH11    = 11'(BLOCK_H);
    localparam logic [10:0]   BHM1_11 = 11'(BLOCK_H - 1);
    localparam logic [10:0]   BW11    = 11'(BLOCK_W);
    localparam logic [9:0]    VL      = 10'(V_LATCH);
    localparam logic [SW-1:0] SUB_MAX = SW'(BLOCK_H - 1);

    typedef enum logic [1:0] {IDLE, LATCH, DIVIDE, READY} state_t;

    state_t      state_q;
    logic [9:0]  sx_q, sy_q;
    logic [31:0] sc_q;
    logic [5:0]  sh_q;
    logic [10:0] r_q;
    logic [5:0]  q_q;
    logic        frame_ready_q;

    logic [5:0]    idx_q, idx_d;
    logic [SW-1:0] sub_q, sub_d;
    logic          valid_q, valid_d;

    logic       hit1_q;
    logic [1:0] code1_q;
    logic       px_q, px_d;
    logic [7:0] rgb_q, rgb_d;

    logic       line_start, snap;
    logic       row_hit, col_hit;
    logic [1:0] code_d;

    assign line_start = sp.pix_en && (sp.hcount == 10'd0);
    assign snap       = line_start && (sp.vcount == VL);

    // Snapshot plus divider: (sy+BLOCK_H-1) / BLOCK_H by repeated
    // subtraction gives the block index and sub-row seen on line 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sx_q          <= '0;
            sy_q          <= '0;
            sc_q          <= '0;
            sh_q          <= '0;
            r_q           <= '0;
            q_q           <= '0;
            frame_ready_q <= 1'b0;
        end else if (snap) begin
            sx_q          <= sp.pos_x;
            sy_q          <= sp.pos_y;
            sc_q          <= sp.colors;
            sh_q          <= (sp.height > 10'd16) ? 6'd16
                                                  : sp.height[5:0];
            state_q       <= LATCH;
            frame_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                LATCH: begin
                    r_q     <= {1'b0, sy_q} + BHM1_11;
                    q_q     <= '0;
                    state_q <= DIVIDE;
                end
                DIVIDE: begin
                    if (r_q >= BH11) begin
                        r_q <= r_q - BH11;
                        q_q <= q_q + 6'd1;
                    end else begin
                        state_q       <= READY;
                        frame_ready_q <= 1'b1;
                    end
                end
                READY: ;
            endcase
        end
    end

    // Row tracker counts down through sub-rows, stepping to the block
    // below whenever a block's last row has been passed.
    always_comb begin
        idx_d   = idx_q;
        sub_d   = sub_q;
        valid_d = valid_q;
        if (line_start) begin
            if (sp.vcount == 10'd0) begin
                if (state_q == READY) begin
                    idx_d   = q_q;
                    sub_d   = r_q[SW-1:0];
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (sp.vcount < VL && valid_q) begin
                if (sub_q == '0) begin
                    if (idx_q == '0) begin
                        valid_d = 1'b0;
                    end else begin
                        idx_d = idx_q - 6'd1;
                        sub_d = SUB_MAX;
                    end
                end else begin
                    sub_d = sub_q - 1'b1;
                end
            end
        end
    end

    // Stage 1 uses the tracker's next state so a line's row applies
    // from its hcount==0 sample onward.
    assign row_hit = valid_d && (idx_d < sh_q);
    assign col_hit = ({1'b0, sp.hcount} >= {1'b0, sx_q}) &&
                     ({1'b0, sp.hcount} < ({1'b0, sx_q} + BW11));
    assign code_d  = sc_q[{idx_d[3:0], 1'b0} +: 2];

    always_comb begin
        px_d  = hit1_q && (code1_q != 2'b00);
        rgb_d = 8'h00;
        if (px_d) begin
            unique case (1'b1)
                code1_q == 2'b01: rgb_d = PAL1;
                code1_q == 2'b10: rgb_d = PAL2;
                code1_q == 2'b11: rgb_d = PAL3;
                default:          rgb_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            sub_q   <= '0;
            valid_q <= 1'b0;
            hit1_q  <= 1'b0;
            code1_q <= 2'b00;
            px_q    <= 1'b0;
            rgb_q   <= 8'h00;
        end else begin
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            valid_q <= valid_d;
            if (sp.pix_en) begin
                hit1_q  <= row_hit && col_hit && sp.video_on;
                code1_q <= code_d;
                px_q    <= px_d;
                rgb_q   <= rgb_d;
            end
        end
    end

    assign sp.rgb         = rgb_q;
    assign sp.stack_px    = px_q;
    assign sp.frame_ready = frame_ready_q;

endmodule
